// File: rtl/ifetch_icache_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage and its cache.
package ifetch_icache_pkg;

    localparam logic [31:0] FETCH_BYTES      = 32'd4;
    localparam logic [3:0]  FETCH_REMAIN     = 4'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_icache_array.sv
// Direct-mapped one-word-per-line storage: combinational lookup, synchronous fill.
module ifetch_icache_array #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_hit,
    output logic [31:0]         rd_data,
    input  logic                we,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data
);

    localparam int unsigned Lines = 2 ** IDX_BITS;

    logic [Lines-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [Lines];
    logic [31:0]         data_q [Lines];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/ifetch_icache.sv
// Fetch stage: PC register, hit/miss FSM, memory request pulse and a one-entry output slot.
module ifetch_icache
    import ifetch_icache_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned ADDR_BITS = 18,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_remain,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned TagBits = ADDR_BITS - IDX_BITS - 2;

    fetch_state_e        state_q;
    logic [31:0]         pc_q;
    logic                mem_req_q;
    logic [31:0]         mem_addr_q;
    logic [3:0]          mem_remain_q;
    logic                inst_valid_q;
    logic [31:0]         inst_data_q;
    logic [31:0]         inst_pc_q;

    logic [IDX_BITS-1:0] idx;
    logic [TagBits-1:0]  tag;
    logic                line_hit;
    logic [31:0]         line_data;
    logic                slot_free;
    logic                fill;
    logic [31:0]         pc_plus4;

    assign idx       = pc_q[IDX_BITS+1:2];
    assign tag       = pc_q[ADDR_BITS-1:IDX_BITS+2];
    assign slot_free = !inst_valid_q || inst_ready;
    assign pc_plus4  = pc_q + FETCH_BYTES;
    // The line is written even when a simultaneous clear discards the forwarded word.
    assign fill      = !rst && rdy && (state_q == StWait) && mem_ready;

    ifetch_icache_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TagBits)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .rd_tag  (tag),
        .rd_hit  (line_hit),
        .rd_data (line_data),
        .we      (fill),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (mem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_remain_q <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_remain_q <= '0;
            if (rdy) begin
                if (clear) begin
                    pc_q         <= clear_pc;
                    inst_valid_q <= 1'b0;
                    state_q      <= StRun;
                end else begin
                    if (inst_valid_q && inst_ready) begin
                        inst_valid_q <= 1'b0;
                    end
                    unique case (state_q)
                        StRun: begin
                            if (slot_free && line_hit) begin
                                inst_valid_q <= 1'b1;
                                inst_data_q  <= line_data;
                                inst_pc_q    <= pc_q;
                                pc_q         <= pc_plus4;
                            end else if (slot_free) begin
                                mem_req_q    <= 1'b1;
                                mem_addr_q   <= pc_q;
                                mem_remain_q <= FETCH_REMAIN;
                                state_q      <= StWait;
                            end
                        end
                        StWait: begin
                            if (mem_ready) begin
                                inst_valid_q <= 1'b1;
                                inst_data_q  <= mem_data;
                                inst_pc_q    <= pc_q;
                                pc_q         <= pc_plus4;
                                state_q      <= StRun;
                            end
                        end
                        default: state_q <= StRun;
                    endcase
                end
            end
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_remain = mem_remain_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifetch_icache.sv
// Directed bench for ifetch_icache: cold miss, hits, stall, clear, conflict and rdy gating.
module tb_ifetch_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [31:0] clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_remain;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int vectors = 0;
    int fails   = 0;
    int req_cnt = 0;
    int cnt0;

    ifetch_icache #(
        .IDX_BITS  (6),
        .ADDR_BITS (18),
        .RESET_PC  (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clear      (clear),
        .clear_pc   (clear_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_remain (mem_remain),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && mem_req === 1'b1) req_cnt++;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next request and check its address and byte count.
    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        step();
        while (mem_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("req_seen", {31'b0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, exp_addr);
        chk("req_remain", {28'b0, mem_remain}, 32'd4);
    endtask

    // Return the word lat cycles after the request; slot loads the cycle after mem_ready.
    task automatic serve(input int lat, input logic [31:0] addr);
        for (int i = 0; i < lat; i++) begin
            step();
            chk("wait_no_req", {31'b0, mem_req}, 32'd0);
            chk("wait_slot_empty", {31'b0, inst_valid}, 32'd0);
        end
        mem_ready = 1'b1;
        mem_data  = mem_word(addr);
        step();
        mem_ready = 1'b0;
        mem_data  = 32'h0;
        chk("fill_valid", {31'b0, inst_valid}, 32'd1);
        chk("fill_pc", inst_pc, addr);
        chk("fill_data", inst_data, mem_word(addr));
    endtask

    initial begin
        rst        = 1'b1;
        rdy        = 1'b1;
        clear      = 1'b0;
        clear_pc   = 32'h0;
        mem_ready  = 1'b0;
        mem_data   = 32'h0;
        inst_ready = 1'b0;
        step();
        step();
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_remain", {28'b0, mem_remain}, 32'd0);
        rst = 1'b0;

        // Cold start: a single miss at 0, word 0x13 returned after 6 cycles.
        wait_req(32'h0);
        serve(6, 32'h0);
        chk("cold_data_13", inst_data, 32'h13);

        // Downstream stall: everything holds, no request.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_pc", inst_pc, 32'h0);
            chk("stall_data", inst_data, 32'h13);
            chk("stall_no_req", {31'b0, mem_req}, 32'd0);
        end
        chk("stall_fetch_pc", dut.pc_q, 32'h4);
        chk("cold_one_req", req_cnt, 32'd1);

        // Warm up 0x10..0x1C.
        inst_ready = 1'b1;
        clear      = 1'b1;
        clear_pc   = 32'h10;
        step();
        clear = 1'b0;
        chk("clear_empties_slot", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_req(32'h10 + 32'(4 * i));
            serve(2, 32'h10 + 32'(4 * i));
        end

        // Clear while waiting on 0x20: nothing from 0x20, next request is 0x40.
        wait_req(32'h20);
        step();
        step();
        clear    = 1'b1;
        clear_pc = 32'h40;
        step();
        clear = 1'b0;
        chk("wclear_slot", {31'b0, inst_valid}, 32'd0);
        chk("wclear_no_req", {31'b0, mem_req}, 32'd0);
        wait_req(32'h40);
        chk("wclear_no_0x20", {31'b0, inst_valid}, 32'd0);
        serve(3, 32'h40);

        // Loop re-executed: four hits on consecutive cycles, no requests.
        clear    = 1'b1;
        clear_pc = 32'h10;
        step();
        clear = 1'b0;
        cnt0  = req_cnt;
        chk("loop_slot_empty", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("loop_valid", {31'b0, inst_valid}, 32'd1);
            chk("loop_pc", inst_pc, 32'h10 + 32'(4 * i));
            chk("loop_data", inst_data, mem_word(32'h10 + 32'(4 * i)));
            chk("loop_no_req", {31'b0, mem_req}, 32'd0);
        end
        chk("loop_req_cnt", req_cnt, cnt0);

        // Conflict: 0x0 hits, 0x100 evicts it, 0x0 then misses.
        clear    = 1'b1;
        clear_pc = 32'h0;
        step();
        clear = 1'b0;
        step();
        chk("conf_hit0_valid", {31'b0, inst_valid}, 32'd1);
        chk("conf_hit0_pc", inst_pc, 32'h0);
        chk("conf_hit0_data", inst_data, 32'h13);
        clear    = 1'b1;
        clear_pc = 32'h100;
        step();
        clear = 1'b0;
        wait_req(32'h100);
        serve(2, 32'h100);
        clear    = 1'b1;
        clear_pc = 32'h0;
        step();
        clear = 1'b0;
        wait_req(32'h0);

        // rdy low for 3 cycles while mem_ready is presented: nothing moves.
        rdy       = 1'b0;
        mem_ready = 1'b1;
        mem_data  = mem_word(32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy0_slot", {31'b0, inst_valid}, 32'd0);
            chk("rdy0_no_req", {31'b0, mem_req}, 32'd0);
            chk("rdy0_pc", dut.pc_q, 32'h0);
        end
        rdy = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("rdy1_valid", {31'b0, inst_valid}, 32'd1);
        chk("rdy1_pc", inst_pc, 32'h0);
        chk("rdy1_data", inst_data, 32'h13);
        chk("rdy1_fetch_pc", dut.pc_q, 32'h4);
        wait_req(32'h4);
        serve(2, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
